exec_mul_sequencer: RTL and testbench
=====================================

Name: exec_mul_sequencer

Overview:
- Multi-cycle multiply controller beside the execute stage; serves MUL, SMULH and UMULH, which the single-cycle ALU cannot complete in one cycle.
- Accepts operands from the execute stage (readData1_E, mux output) and runs an iterative radix-2 shift-add over N cycles.
- Holds the pipeline with stall_E until the product is ready, then presents the result for the execute-stage result mux.

Parameters:
- N, 64, operand width in bits; iteration count = N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  multiply request from decode/control, qualified in IDLE only.
- flush  input  1  abort the current operation (branch flush).
- op_a  input  N  multiplicand.
- op_b  input  N  multiplier.
- is_signed  input  1  1 = two's-complement operands (MUL, SMULH); 0 = unsigned (UMULH).
- hi_sel  input  1  1 = return high N bits of the 2N product; 0 = return low N bits.
- busy  output  1  high in RUN.
- stall_E  output  1  pipeline hold request.
- done  output  1  one-cycle result-valid pulse.
- result  output  N  selected product half; held until next accepted start.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, internal accumulator/counter=0. Reset overrides flush and start in the same cycle. Reset mid-RUN abandons the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE and start=1 (flush=0):
  - Latch |op_a| and |op_b| when is_signed=1, else the raw values.
  - Latch neg = is_signed & (op_a[N-1] ^ op_b[N-1]), and latch hi_sel.
  - Clear the 2N-bit accumulator; load count=N-1; go to RUN.
- RUN, each cycle:
  - If multiplier LSB=1, add the multiplicand into the accumulator upper half.
  - Shift {carry, acc, multiplier} right by 1.
  - count==0 -> DONE, else count-1. RUN lasts exactly N cycles.
- DONE (one cycle):
  - p = neg ? (~acc + 1) : acc, computed mod 2^(2N).
  - result <= hi_sel ? p[2N-1:N] : p[N-1:0], registered on entry to DONE so it is visible during DONE.
  - done=1; next state IDLE.
  - A start in DONE is ignored; a new request must be presented in IDLE.
- Latency: start accepted at cycle t -> done=1 at cycle t+N+1. Fixed; no early termination for zero or one operands.
- stall_E = (IDLE & start & ~flush) | RUN. Combinational from state and inputs. Deasserted in DONE so the instruction retires with result.
- busy = RUN (registered state decode).
- flush=1 in RUN or DONE -> IDLE next cycle, done suppressed, result unchanged. flush in IDLE blocks acceptance of start.
- start while busy: ignored; no queueing.
- Overflow: low half wraps mod 2^N (MUL semantics); no overflow flag.
- Edge case: the most negative value (e.g. 0x8000...0) as a signed operand takes magnitude 2^(N-1), representable unsigned in N bits. The product must be correct.

Test Plan:
- Reset during RUN (cycle 10 of 64) -> IDLE next cycle, result=0, no done pulse, stall_E=0.
- Unsigned: op_a=0xFFFFFFFFFFFFFFFF, op_b=2, is_signed=0, hi_sel=0 -> done at t+65, result=0xFFFFFFFFFFFFFFFE. Repeat with hi_sel=1 -> result=0x1.
- Signed: op_a=-3, op_b=7, is_signed=1 -> low result=0xFFFFFFFFFFFFFFEB, high result=0xFFFFFFFFFFFFFFFF. Also op_a=0x8000000000000000, op_b=-1, hi_sel=1 -> result=0x0 (SMULH); low result=0x8000000000000000.
- Stall timing: stall_E=1 from the start cycle through the last RUN cycle (65 cycles), 0 in the DONE cycle. A second start asserted mid-RUN is ignored and result is unaffected.
- Flush at RUN cycle 30 -> IDLE next cycle, no done, result keeps its previous value. A start 2 cycles later is accepted normally.
- Zero operand: op_a=0, op_b=12345 -> result=0, still 65-cycle latency. Back-to-back: start in the IDLE cycle right after DONE is accepted.

Source files
------------

// File: rtl/exec_mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for MUL/SMULH/UMULH beside the execute stage.
// Signed operands are multiplied as magnitudes; the sign is applied to the 2N-bit product.
module exec_mul_sequencer #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         flush,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         is_signed,
    input  logic         hi_sel,
    output logic         busy,
    output logic         stall_E,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           hi_q, hi_d;
    logic [N-1:0]   result_q, result_d;

    logic [N:0]     sum;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] p;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        result_d = result_q;

        // One iteration: conditional add into the upper half, then shift {carry, acc, mplier} right.
        sum  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod = {sum[N:1], sum[0], mplier_q[N-1:1]};
        p    = neg_q ? -prod : prod;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    mcand_d  = (is_signed && op_a[N-1]) ? -op_a : op_a;
                    mplier_d = (is_signed && op_b[N-1]) ? -op_b : op_b;
                    neg_d    = is_signed & (op_a[N-1] ^ op_b[N-1]);
                    hi_d     = hi_sel;
                    acc_d    = '0;
                    cnt_d    = CW'(N - 1);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = prod[2*N-1:N];
                    mplier_d = prod[N-1:0];
                    if (cnt_q == '0) begin
                        // Final product is formed from this iteration's output so result is valid in DONE.
                        result_d = hi_q ? p[2*N-1:N] : p[N-1:0];
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            result_q <= result_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign stall_E = ((state_q == IDLE) && start && !flush) || (state_q == RUN);
    assign done    = (state_q == DONE) && !flush;
    assign result  = result_q;
endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Directed-vector bench for exec_mul_sequencer: latency, stall window, signed/unsigned halves, flush, reset.
module tb_exec_mul_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, flush, is_signed, hi_sel;
    logic [63:0] op_a, op_b;
    logic        busy, stall_E, done;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    logic [63:0] r_res;
    int r_done_cyc, r_done_cnt, r_stall_cnt, r_busy_cnt;
    logic r_stall_at_done;

    exec_mul_sequencer #(.N(64)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .op_a(op_a), .op_b(op_b), .is_signed(is_signed), .hi_sel(hi_sel),
        .busy(busy), .stall_E(stall_E), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Runs ncyc cycles starting in the current cycle (cycle 0 = start cycle); ends aligned just after a rising edge.
    task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input logic s, input logic h,
                          input int flush_at, input int restart_at, input int ncyc);
        r_res = 'x; r_done_cyc = -1; r_done_cnt = 0; r_stall_cnt = 0; r_busy_cnt = 0;
        r_stall_at_done = 1'bx;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (cyc == 0) begin
                op_a = a; op_b = b; is_signed = s; hi_sel = h; start = 1'b1;
            end else if (cyc == restart_at) begin
                op_a = 64'hDEAD_BEEF_0000_0003; op_b = 64'h3; is_signed = ~s; hi_sel = ~h; start = 1'b1;
            end else begin
                op_a = 64'hFFFF_0000_FFFF_0000; op_b = 64'h5555; start = 1'b0;
            end
            flush = (cyc == flush_at);
            #1;
            if (stall_E) r_stall_cnt++;
            if (busy) r_busy_cnt++;
            if (done) begin
                r_done_cnt++; r_done_cyc = cyc; r_res = result; r_stall_at_done = stall_E;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; flush = 1'b0; is_signed = 1'b0; hi_sel = 1'b0;
        op_a = 64'd3; op_b = 64'd4;
        repeat (2) @(posedge clk);
        #1; start = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (stall_E !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_E); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL umul_lo got=%h exp=fffffffffffffffe", r_res); end
        total++; if (r_done_cyc !== 65) begin bad++; $display("FAIL umul_latency got=%0d exp=65", r_done_cyc); end
        total++; if (r_done_cnt !== 1) begin bad++; $display("FAIL umul_done_pulses got=%0d exp=1", r_done_cnt); end
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1, -1, -1, 66);
        total++; if (r_res !== 64'h1) begin bad++; $display("FAIL umulh got=%h exp=1", r_res); end
        total++; if (r_done_cyc !== 65) begin bad++; $display("FAIL umulh_latency got=%0d exp=65", r_done_cyc); end
    endtask

    task automatic test_signed();
        do_mul(-64'sd3, 64'd7, 1'b1, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL smul_lo got=%h exp=ffffffffffffffeb", r_res); end
        do_mul(-64'sd3, 64'd7, 1'b1, 1'b1, -1, -1, 66);
        total++; if (r_res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL smulh got=%h exp=ffffffffffffffff", r_res); end
        do_mul(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, -1, -1, 66);
        total++; if (r_res !== 64'h0) begin bad++; $display("FAIL smulh_minneg got=%h exp=0", r_res); end
        do_mul(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL smul_minneg_lo got=%h exp=8000000000000000", r_res); end
    endtask

    task automatic test_stall_and_ignore();
        do_mul(64'd5, 64'd6, 1'b0, 1'b0, -1, 20, 66);
        total++; if (r_stall_cnt !== 65) begin bad++; $display("FAIL stall_cycles got=%0d exp=65", r_stall_cnt); end
        total++; if (r_stall_at_done !== 1'b0) begin bad++; $display("FAIL stall_in_done got=%0b exp=0", r_stall_at_done); end
        total++; if (r_busy_cnt !== 64) begin bad++; $display("FAIL busy_cycles got=%0d exp=64", r_busy_cnt); end
        total++; if (r_res !== 64'd30) begin bad++; $display("FAIL ignore_midrun_start got=%h exp=1e", r_res); end
        total++; if (r_done_cnt !== 1) begin bad++; $display("FAIL ignore_midrun_pulses got=%0d exp=1", r_done_cnt); end
    endtask

    task automatic test_back_to_back();
        // Previous task ended in the IDLE cycle right after DONE.
        do_mul(64'h1234, 64'h10, 1'b0, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'h12340) begin bad++; $display("FAIL b2b_result got=%h exp=12340", r_res); end
        total++; if (r_done_cyc !== 65) begin bad++; $display("FAIL b2b_latency got=%0d exp=65", r_done_cyc); end
    endtask

    task automatic test_flush();
        do_mul(64'd9, 64'd9, 1'b0, 1'b0, 30, -1, 33);
        total++; if (r_done_cnt !== 0) begin bad++; $display("FAIL flush_done got=%0d exp=0", r_done_cnt); end
        total++; if (r_stall_cnt !== 31) begin bad++; $display("FAIL flush_stall got=%0d exp=31", r_stall_cnt); end
        total++; if (r_busy_cnt !== 30) begin bad++; $display("FAIL flush_busy got=%0d exp=30", r_busy_cnt); end
        total++; if (result !== 64'h12340) begin bad++; $display("FAIL flush_result_kept got=%h exp=12340", result); end
        // Two cycles after the flush took effect.
        do_mul(64'd3, 64'd4, 1'b0, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'd12) begin bad++; $display("FAIL post_flush_result got=%h exp=c", r_res); end
        total++; if (r_done_cyc !== 65) begin bad++; $display("FAIL post_flush_latency got=%0d exp=65", r_done_cyc); end
    endtask

    task automatic test_zero();
        do_mul(64'd0, 64'd12345, 1'b0, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'h0) begin bad++; $display("FAIL zero_result got=%h exp=0", r_res); end
        total++; if (r_done_cyc !== 65) begin bad++; $display("FAIL zero_latency got=%0d exp=65", r_done_cyc); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        // Load a nonzero result first so the reset clearing it is observable.
        do_mul(64'd7, 64'd9, 1'b0, 1'b0, -1, -1, 66);
        total++; if (r_res !== 64'd63) begin bad++; $display("FAIL pre_reset_result got=%h exp=3f", r_res); end
        do_mul(64'd11, 64'd13, 1'b0, 1'b0, -1, -1, 10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_reset_busy got=%0b exp=0", busy); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL midrun_reset_result got=%h exp=0", result); end
        total++; if (stall_E !== 1'b0) begin bad++; $display("FAIL midrun_reset_stall got=%0b exp=0", stall_E); end
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrun_reset_done got=%0d exp=0", pulses); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_stall_and_ignore();
        test_back_to_back();
        test_flush();
        test_zero();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
